// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: default sizing,
// byte-enable patterns, the legal-pattern check and the response FSM states.
package dmem_pkg;

    // Default word-address width (2^13 words of 32 bits).
    localparam int ADDR_W_DEFAULT = 13;

    // Byte-enable patterns a requester may legally issue.
    localparam logic [3:0] BE_BYTE0 = 4'b0001;
    localparam logic [3:0] BE_BYTE1 = 4'b0010;
    localparam logic [3:0] BE_BYTE2 = 4'b0100;
    localparam logic [3:0] BE_BYTE3 = 4'b1000;
    localparam logic [3:0] BE_HALF0 = 4'b0011;
    localparam logic [3:0] BE_HALF1 = 4'b1100;
    localparam logic [3:0] BE_WORD  = 4'b1111;

    // Response-path state: EMPTY means no response is being presented.
    typedef logic [0:0] rspState_t;
    localparam rspState_t RSP_EMPTY = 1'b0;
    localparam rspState_t RSP_FULL  = 1'b1;

    // True only for aligned byte, halfword and word accesses; 0000 is illegal.
    function automatic logic isLegalBe(input logic [3:0] be);
        case (be)
            BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3,
            BE_HALF0, BE_HALF1, BE_WORD: isLegalBe = 1'b1;
            default:                     isLegalBe = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_bank.sv
// One byte lane of the data memory: a 2^ADDR_W x 8 synchronous RAM with a
// single write enable and a registered read port that only updates when a
// read is requested, so the read word holds while a response is stalled.
module dmem_lane_bank
    import dmem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0] mem [DEPTH];
    logic [7:0] rdataReg;

    // Write the lane when enabled; capture the addressed byte on a read.
    // Contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdataReg <= mem[addr];
        end
    end

    assign rdata = rdataReg;

endmodule

// File: rtl/dmem_responder.sv
// Single-cycle data-memory responder. Accepts one load/store per cycle,
// answers one cycle later through a one-entry response register governed by
// an EMPTY/FULL FSM, flags illegal byte-enable patterns and counts them.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEFAULT,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [3:0]           req_be,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_is_store,
    output logic                 rsp_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

    rspState_t            stateReg;
    rspState_t            stateNext;
    logic                 rspIsLoadReg;
    logic                 rspIsStoreReg;
    logic                 rspErrReg;
    logic [ERR_CNT_W-1:0] errCountReg;

    logic                 accept;
    logic                 beLegal;
    logic                 doWrite;
    logic                 doRead;
    logic [7:0]           laneRdata [4];
    logic [31:0]          loadWord;

    // A new request fits whenever the response slot is empty or being drained;
    // nothing is accepted while reset is held.
    assign rsp_valid = (stateReg == RSP_FULL);
    assign req_ready = rst && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign beLegal   = isLegalBe(req_be);
    assign doWrite   = accept && req_we && beLegal;
    assign doRead    = accept && !req_we && beLegal;

    // Four independent byte lanes; each store lane is gated by its enable,
    // loads always read all four lanes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            dmem_lane_bank #(
                .ADDR_W (ADDR_W)
            ) u_bank (
                .clk   (clk),
                .we    (doWrite && req_be[gi]),
                .re    (doRead),
                .addr  (req_addr),
                .wdata (req_wdata[8*gi +: 8]),
                .rdata (laneRdata[gi])
            );
            assign loadWord[8*gi +: 8] = laneRdata[gi];
        end
    endgenerate

    // The lane read registers hold the captured word; only a legal load
    // response exposes it, everything else reports zero data.
    assign rsp_rdata    = rspIsLoadReg ? loadWord : 32'h0;
    assign rsp_is_store = rspIsStoreReg;
    assign rsp_err      = rspErrReg;
    assign err_count    = errCountReg;

    // Response FSM: fill on accept, drain when consumed with nothing new.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            RSP_EMPTY: begin
                if (accept) begin
                    stateNext = RSP_FULL;
                end
            end
            RSP_FULL: begin
                if (rsp_ready && !accept) begin
                    stateNext = RSP_EMPTY;
                end
            end
            default: stateNext = RSP_EMPTY;
        endcase
    end

    // Response registers and the saturating error counter; a pending
    // response is discarded on reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stateReg      <= RSP_EMPTY;
            rspIsLoadReg  <= 1'b0;
            rspIsStoreReg <= 1'b0;
            rspErrReg     <= 1'b0;
            errCountReg   <= '0;
        end else begin
            stateReg <= stateNext;
            if (accept) begin
                rspIsLoadReg  <= !req_we && beLegal;
                rspIsStoreReg <= req_we;
                rspErrReg     <= !beLegal;
                if (!beLegal && (errCountReg != ERR_MAX)) begin
                    errCountReg <= errCountReg + ERR_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, hand-written
// stall/reset/saturation sequences, then randomized traffic against a
// word-level memory model.
module tb_dmem_responder;

    localparam int AW    = 6;
    localparam int CW    = 4;
    localparam int WORDS = 1 << AW;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [3:0]    req_be;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_is_store;
    logic          rsp_err;
    logic [CW-1:0] err_count;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] mMem [WORDS];
    bit          mMemKnown [WORDS];
    bit          mValid;
    logic [31:0] mRdata;
    bit          mIsStore;
    bit          mErr;
    bit          mKnown;
    bit          mJustReset;
    int          mCnt;

    typedef struct {
        bit          r;
        bit          rv;
        bit          we;
        logic [5:0]  addr;
        logic [3:0]  be;
        logic [31:0] wd;
        bit          rr;
        bit          expValid;
        logic [31:0] expRdata;
        bit          expIsStore;
        bit          expErr;
        logic [3:0]  expCnt;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    dmem_responder #(
        .ADDR_W    (AW),
        .ERR_CNT_W (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_be       (req_be),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_is_store (rsp_is_store),
        .rsp_err      (rsp_err),
        .err_count    (err_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check req_ready before the edge,
    // advance the model, check outputs after the edge, return at next negedge.
    task automatic cycle(input bit r, input bit rv, input bit we, input logic [5:0] a,
                         input logic [3:0] be, input logic [31:0] wd, input bit rr);
        bit ready;
        bit acc;
        bit legal;
        rst       = r;
        req_valid = rv;
        req_we    = we;
        req_addr  = a;
        req_be    = be;
        req_wdata = wd;
        rsp_ready = rr;
        #1;
        ready = r && (!mValid || rr);
        chk("req_ready", {31'b0, req_ready}, {31'b0, ready});
        acc   = rv && ready;
        legal = (be == 4'b0001) || (be == 4'b0010) || (be == 4'b0100) || (be == 4'b1000) ||
                (be == 4'b0011) || (be == 4'b1100) || (be == 4'b1111);
        if (!r) begin
            mValid = 0; mRdata = 0; mIsStore = 0; mErr = 0; mKnown = 1; mCnt = 0;
            mJustReset = 1;
        end else begin
            mJustReset = 0;
            if (acc) begin
                mValid = 1;
                if (!legal) begin
                    mRdata = 0; mErr = 1; mIsStore = we; mKnown = 1;
                    if (mCnt < CMAX) mCnt++;
                end else if (we) begin
                    for (int i = 0; i < 4; i++)
                        if (be[i]) mMem[a][8*i +: 8] = wd[8*i +: 8];
                    if (be == 4'b1111) mMemKnown[a] = 1;
                    mRdata = 0; mErr = 0; mIsStore = 1; mKnown = 1;
                end else begin
                    mRdata = mMem[a]; mKnown = mMemKnown[a]; mErr = 0; mIsStore = 0;
                end
            end else if (rr) begin
                mValid = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, mValid});
        if (mValid || mJustReset) begin
            chk("rsp_is_store", {31'b0, rsp_is_store}, {31'b0, mIsStore});
            chk("rsp_err", {31'b0, rsp_err}, {31'b0, mErr});
            if (mKnown) chk("rsp_rdata", rsp_rdata, mRdata);
        end
        chk("err_count", {28'b0, err_count}, mCnt);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] cap;
        bit          r;
        logic [3:0]  be;
        logic [3:0]  legalBe [7];
        legalBe = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        for (int i = 0; i < WORDS; i++) begin
            mMem[i] = 32'h0;
            mMemKnown[i] = 0;
        end
        mValid = 0; mRdata = 0; mIsStore = 0; mErr = 0; mKnown = 0; mCnt = 0; mJustReset = 0;

        //          r  rv we addr be     wdata         rr  v  rdata         st err cnt
        vecs[0] = '{1, 1, 1, 6'd5, 4'hF, 32'hDEADBEEF, 1, 1, 32'h00000000, 1, 0, 4'd0};
        vecs[1] = '{1, 1, 0, 6'd5, 4'hF, 32'h00000000, 1, 1, 32'hDEADBEEF, 0, 0, 4'd0};
        vecs[2] = '{1, 1, 1, 6'd5, 4'h4, 32'h00AA0000, 1, 1, 32'h00000000, 1, 0, 4'd0};
        vecs[3] = '{1, 1, 0, 6'd5, 4'hF, 32'h00000000, 1, 1, 32'hDEAABEEF, 0, 0, 4'd0};
        vecs[4] = '{1, 1, 1, 6'd5, 4'h6, 32'hFFFFFFFF, 1, 1, 32'h00000000, 1, 1, 4'd1};
        vecs[5] = '{1, 1, 0, 6'd5, 4'hF, 32'h00000000, 1, 1, 32'hDEAABEEF, 0, 0, 4'd1};
        vecs[6] = '{1, 1, 0, 6'd5, 4'h0, 32'h00000000, 1, 1, 32'h00000000, 0, 1, 4'd2};
        vecs[7] = '{1, 0, 0, 6'd0, 4'h0, 32'h00000000, 1, 0, 32'h00000000, 0, 0, 4'd2};

        rst = 0; req_valid = 0; req_we = 0; req_addr = '0; req_be = '0; req_wdata = '0;
        rsp_ready = 0;
        @(negedge clk);

        // Reset state
        cycle(0, 0, 0, 6'd0, 4'h0, 32'h0, 0);
        cycle(0, 1, 1, 6'd3, 4'hF, 32'h12345678, 1);
        chk("reset rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("reset rsp_rdata", rsp_rdata, 32'h0);
        chk("reset rsp_is_store", {31'b0, rsp_is_store}, 32'h0);
        chk("reset rsp_err", {31'b0, rsp_err}, 32'h0);
        chk("reset err_count", {28'b0, err_count}, 32'h0);
        chk("reset req_ready", {31'b0, req_ready}, 32'h0);

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].r, vecs[i].rv, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wd, vecs[i].rr);
            $display("vec %0d: valid=%0d rdata=%h st=%0d err=%0d cnt=%0d", i, rsp_valid, rsp_rdata,
                     rsp_is_store, rsp_err, err_count);
            chk($sformatf("vec%0d valid", i), {31'b0, rsp_valid}, {31'b0, vecs[i].expValid});
            if (vecs[i].expValid) begin
                chk($sformatf("vec%0d rdata", i), rsp_rdata, vecs[i].expRdata);
                chk($sformatf("vec%0d is_store", i), {31'b0, rsp_is_store}, {31'b0, vecs[i].expIsStore});
                chk($sformatf("vec%0d err", i), {31'b0, rsp_err}, {31'b0, vecs[i].expErr});
            end
            chk($sformatf("vec%0d err_count", i), {28'b0, err_count}, {28'b0, vecs[i].expCnt});
        end

        // Stall: response holds for 3 cycles, store attempts are refused
        cycle(1, 1, 0, 6'd5, 4'hF, 32'h0, 1);
        cap = rsp_rdata;
        chk("stall load data", cap, 32'hDEAABEEF);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 1, 6'd5, 4'hF, 32'h0BADF00D, 0);
            $display("stall %0d: valid=%0d rdata=%h req_ready=%0d", i, rsp_valid, rsp_rdata, req_ready);
            chk("stall req_ready", {31'b0, req_ready}, 32'h0);
            chk("stall valid", {31'b0, rsp_valid}, 32'h1);
            chk("stall rdata", rsp_rdata, cap);
            chk("stall is_store", {31'b0, rsp_is_store}, 32'h0);
            chk("stall err", {31'b0, rsp_err}, 32'h0);
        end

        // Back-to-back loads, one response per cycle in order
        cycle(1, 1, 1, 6'd6, 4'hF, 32'h01020304, 1);
        cycle(1, 1, 0, 6'd5, 4'hF, 32'h0, 1);
        chk("b2b load0", rsp_rdata, 32'hDEAABEEF);
        cycle(1, 1, 0, 6'd6, 4'hF, 32'h0, 1);
        chk("b2b load1", rsp_rdata, 32'h01020304);
        cycle(1, 1, 0, 6'd5, 4'hF, 32'h0, 1);
        chk("b2b load2", rsp_rdata, 32'hDEAABEEF);
        $display("b2b: last rdata=%h", rsp_rdata);

        // Reset during a pending response with a store to addr 7 presented
        cycle(1, 1, 1, 6'd7, 4'hF, 32'h11223344, 1);
        cycle(1, 1, 0, 6'd7, 4'hF, 32'h0, 0);
        cycle(0, 1, 1, 6'd7, 4'hF, 32'hFFFFFFFF, 0);
        chk("rstpend valid", {31'b0, rsp_valid}, 32'h0);
        chk("rstpend err_count", {28'b0, err_count}, 32'h0);
        cycle(1, 1, 0, 6'd7, 4'hF, 32'h0, 1);
        chk("rstpend addr7", rsp_rdata, 32'h11223344);
        $display("reset seq: addr7=%h", rsp_rdata);

        // Error counter saturation
        for (int i = 0; i < CMAX - 1; i++) cycle(1, 1, i[0], 6'd9, 4'h5, 32'h0, 1);
        chk("sat pre", {28'b0, err_count}, CMAX - 1);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 1, 6'd9, 4'h0, 32'h0, 1);
            chk("sat", {28'b0, err_count}, CMAX);
        end
        $display("saturation: err_count=%0d", err_count);
        cycle(0, 0, 0, 6'd0, 4'h0, 32'h0, 1);

        // Fill memory with known words, then random traffic
        for (int i = 0; i < WORDS; i++) cycle(1, 1, 1, i[5:0], 4'hF, $urandom, 1);
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 49) != 0);
            be = ($urandom_range(0, 4) != 0) ? legalBe[$urandom_range(0, 6)] : 4'($urandom);
            cycle(r, 1'($urandom), 1'($urandom), 6'($urandom), be, $urandom,
                  ($urandom_range(0, 9) < 7));
        end
        $display("random phase done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Overall time bound
    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_W, default 13, word-address width (2^ADDR_W 32-bit words).
REQ-002 Parameter ERR_CNT_W, default 16, width of the saturating error counter.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low; the block is in reset when rst is 0 at a rising clk edge.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  ADDR_W  word address.
REQ-009 req_be  input  4  byte-lane enables; lane i is bits [8i+7:8i].
REQ-010 req_wdata  input  32  store data, lane-aligned.
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  consumer accepts the response.
REQ-013 rsp_rdata  output  32  raw load word; the requester does lane select and sign extension.
REQ-014 rsp_is_store  output  1  response belongs to a store.
REQ-015 rsp_err  output  1  request had an illegal byte-enable pattern.
REQ-016 err_count  output  ERR_CNT_W  number of error responses generated.

Function
REQ-017 req_ready SHALL equal (!rsp_valid || rsp_ready), combinationally.
REQ-018 A request SHALL be accepted on a rising edge where req_valid && req_ready.
REQ-019 Legal req_be patterns SHALL be 0001, 0010, 0100, 1000, 0011, 1100 and 1111; every other pattern, including 0000, is illegal.
REQ-020 An accepted legal store SHALL write exactly the enabled lanes of word req_addr at the acceptance edge; disabled lanes are unchanged.
REQ-021 An accepted legal load SHALL capture word req_addr, all four lanes, at the acceptance edge.
REQ-022 The response for any accepted request SHALL assert rsp_valid on the cycle after the acceptance edge (latency 1).
REQ-023 Load response: rsp_rdata = captured word, rsp_is_store=0, rsp_err=0.
REQ-024 Store response: rsp_rdata=0, rsp_is_store=1, rsp_err=0.
REQ-025 Illegal request: no array write; rsp_rdata=0, rsp_err=1, rsp_is_store=req_we.
REQ-026 While rsp_valid=1 && rsp_ready=0, all rsp_* outputs SHALL hold stable and req_ready SHALL be 0.
REQ-027 When rsp_ready=1 and a new request is accepted in the same cycle, the response register SHALL be overwritten, giving one transaction per cycle.
REQ-028 When rsp_ready=1 and no request is accepted, rsp_valid SHALL fall to 0 on the next edge.
REQ-029 A load accepted on the cycle after a store to the same address SHALL return the post-store word.
REQ-030 err_count SHALL increment by 1 on each acceptance edge of an illegal request and SHALL saturate at all-ones.
REQ-031 The response path SHALL be a two-state FSM: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - EMPTY->FULL on accept.
  - FULL->EMPTY on rsp_ready with no accept.
  - FULL->FULL on stall, or on accept together with rsp_ready.

Reset
REQ-032 In reset: rsp_valid=0, rsp_rdata=0, rsp_is_store=0, rsp_err=0, err_count=0, FSM=EMPTY.
REQ-033 req_ready SHALL be 0 while rst=0.
REQ-034 A request presented on a reset edge SHALL be ignored: no array write, no counter change.
REQ-035 A pending response at reset assertion SHALL be discarded.
REQ-036 Memory array contents SHALL NOT be reset.

Structure
REQ-037 The shared package (dmem_pkg) SHALL hold:
  - the default ADDR_W;
  - the byte-enable pattern constants;
  - a legal-pattern check function;
  - the FSM state typedef.
REQ-038 One sub-module, dmem_lane_bank (2^ADDR_W x 8 synchronous RAM, single write enable), SHALL be instantiated four times, one per lane.
REQ-039 All response registers and the FSM SHALL reside in dmem_responder.

Verification
REQ-040 Store addr 5, be 1111, wdata 0xDEADBEEF; next cycle load addr 5 -> load response rdata 0xDEADBEEF, err 0, is_store 0.
REQ-041 Store addr 5, be 0100, wdata 0x00AA0000 over 0xDEADBEEF -> later load returns 0xDEAABEEF.
REQ-042 Store with be 0110 -> rsp_err=1, rdata 0, err_count 0->1; load addr 5 returns unchanged data.
REQ-043 Hold rsp_ready=0 for 3 cycles after a load -> req_ready=0 and rsp_* stable for 3 cycles; rsp_ready=1 with back-to-back loads -> one response per cycle, in order.
REQ-044 Reset (rst=0) asserted while rsp_valid=1 and req_valid=1 (store addr 7) -> next cycle rsp_valid=0, err_count=0, and a later load of addr 7 shows the old contents.
REQ-045 Force err_count to all-ones minus 1, issue 3 illegal requests -> count saturates at all-ones.
